// File: rtl/feedback_scorer.sv
// rtl/feedback_scorer.sv - multi-cycle Mastermind scorer: exact then partial matches, sticky win/game_over
// One slot per cycle in EXACT, one (guess, secret) slot pair per cycle in PARTIAL.
module feedback_scorer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       last_turn,
  input  logic [2:0] secret3,
  input  logic [2:0] secret2,
  input  logic [2:0] secret1,
  input  logic [2:0] secret0,
  input  logic [2:0] guess3,
  input  logic [2:0] guess2,
  input  logic [2:0] guess1,
  input  logic [2:0] guess0,
  output logic [2:0] exact,
  output logic [2:0] partial,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXACT,
    S_PARTIAL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][2:0] g_q, g_d;
  logic [3:0][2:0] s_q, s_d;
  logic [3:0]      used_g_q, used_g_d;
  logic [3:0]      used_s_q, used_s_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      ex_cnt_q, ex_cnt_d;
  logic [2:0]      pa_cnt_q, pa_cnt_d;
  logic            last_q, last_d;
  logic [2:0]      exact_q, exact_d;
  logic [2:0]      partial_q, partial_d;
  logic            done_q, done_d;
  logic            win_q, win_d;
  logic            game_over_q, game_over_d;

  // idx is the slot k in EXACT; in PARTIAL its upper half is guess slot i, lower half secret slot j.
  logic [1:0] i_sel;
  logic [1:0] j_sel;
  assign i_sel = idx_q[3:2];
  assign j_sel = idx_q[1:0];

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    s_d         = s_q;
    used_g_d    = used_g_q;
    used_s_d    = used_s_q;
    idx_d       = idx_q;
    ex_cnt_d    = ex_cnt_q;
    pa_cnt_d    = pa_cnt_q;
    last_d      = last_q;
    exact_d     = exact_q;
    partial_d   = partial_q;
    done_d      = 1'b0;
    win_d       = win_q;
    game_over_d = game_over_q;

    case (state_q)
      S_IDLE: begin
        if (start && !game_over_q) begin
          g_d      = {guess3, guess2, guess1, guess0};
          s_d      = {secret3, secret2, secret1, secret0};
          used_g_d = 4'b0000;
          used_s_d = 4'b0000;
          ex_cnt_d = 3'd0;
          pa_cnt_d = 3'd0;
          last_d   = last_turn;
          idx_d    = 4'd0;
          state_d  = S_EXACT;
        end
      end
      S_EXACT: begin
        if (g_q[j_sel] == s_q[j_sel]) begin
          ex_cnt_d        = ex_cnt_q + 3'd1;
          used_g_d[j_sel] = 1'b1;
          used_s_d[j_sel] = 1'b1;
        end
        idx_d = idx_q + 4'd1;
        if (j_sel == 2'd3) begin
          idx_d   = 4'd0;
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        // Greedy first-fit over unused slots yields the maximal duplicate-aware pairing.
        if (!used_g_q[i_sel] && !used_s_q[j_sel] && (g_q[i_sel] == s_q[j_sel])) begin
          pa_cnt_d        = pa_cnt_q + 3'd1;
          used_g_d[i_sel] = 1'b1;
          used_s_d[j_sel] = 1'b1;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'hf) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        exact_d   = ex_cnt_q;
        partial_d = pa_cnt_q;
        done_d    = 1'b1;
        if (ex_cnt_q == 3'd4) begin
          win_d = 1'b1;
        end
        if ((ex_cnt_q == 3'd4) || last_q) begin
          game_over_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      s_q         <= '0;
      used_g_q    <= 4'b0000;
      used_s_q    <= 4'b0000;
      idx_q       <= 4'd0;
      ex_cnt_q    <= 3'd0;
      pa_cnt_q    <= 3'd0;
      last_q      <= 1'b0;
      exact_q     <= 3'd0;
      partial_q   <= 3'd0;
      done_q      <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      s_q         <= s_d;
      used_g_q    <= used_g_d;
      used_s_q    <= used_s_d;
      idx_q       <= idx_d;
      ex_cnt_q    <= ex_cnt_d;
      pa_cnt_q    <= pa_cnt_d;
      last_q      <= last_d;
      exact_q     <= exact_d;
      partial_q   <= partial_d;
      done_q      <= done_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign busy      = (state_q == S_EXACT) || (state_q == S_PARTIAL);
  assign exact     = exact_q;
  assign partial   = partial_q;
  assign done      = done_q;
  assign win       = win_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_feedback_scorer.sv
// tb/tb_feedback_scorer.sv - self-checking bench for feedback_scorer against a counting model
module tb_feedback_scorer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       last_turn;
  logic [2:0] sec [4];
  logic [2:0] gs  [4];
  logic [2:0] exact;
  logic [2:0] partial;
  logic       busy;
  logic       done;
  logic       win;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  feedback_scorer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_turn (last_turn),
    .secret3   (sec[3]),
    .secret2   (sec[2]),
    .secret1   (sec[1]),
    .secret0   (sec[0]),
    .guess3    (gs[3]),
    .guess2    (gs[2]),
    .guess1    (gs[1]),
    .guess0    (gs[0]),
    .exact     (exact),
    .partial   (partial),
    .busy      (busy),
    .done      (done),
    .win       (win),
    .game_over (game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Mastermind scoring from symbol histograms: partial = shared symbols minus exact hits.
  function automatic void score(input logic [11:0] sv, input logic [11:0] gv,
                                output int ex, output int pa);
    int cs[8];
    int cg[8];
    int common;
    ex = 0;
    common = 0;
    for (int v = 0; v < 8; v++) begin
      cs[v] = 0;
      cg[v] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (sv[3*k +: 3] == gv[3*k +: 3]) ex++;
      cs[sv[3*k +: 3]]++;
      cg[gv[3*k +: 3]]++;
    end
    for (int v = 0; v < 8; v++) common += (cs[v] < cg[v]) ? cs[v] : cg[v];
    pa = common - ex;
  endfunction

  // Model: a job accepted at edge N publishes its result at edge N+21.
  bit m_active = 0;
  int m_age = 0;
  int p_ex, p_pa;
  bit p_last;
  int m_ex = 0, m_pa = 0;
  bit m_done = 0, m_win = 0, m_go = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 0;
        m_ex = 0; m_pa = 0;
        m_done = 0; m_win = 0; m_go = 0;
      end else begin
        m_done = 0;
        if (m_active) begin
          m_age++;
          if (m_age == 21) begin
            m_ex = p_ex;
            m_pa = p_pa;
            m_done = 1;
            if (p_ex == 4) m_win = 1;
            if (p_ex == 4 || p_last) m_go = 1;
            m_active = 0;
          end
        end else if (start && !m_go) begin
          score({sec[3], sec[2], sec[1], sec[0]}, {gs[3], gs[2], gs[1], gs[0]}, p_ex, p_pa);
          p_last = last_turn;
          m_active = 1;
          m_age = 0;
        end
      end
      @(negedge clk);
      check("exact", exact, m_ex);
      check("partial", partial, m_pa);
      check("busy", busy, (m_active && m_age < 20) ? 1 : 0);
      check("done", done, m_done);
      check("win", win, m_win);
      check("game_over", game_over, m_go);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int a3, input int a2, input int a1, input int a0,
                          input int b3, input int b2, input int b1, input int b0);
    sec[3] = a3[2:0]; sec[2] = a2[2:0]; sec[1] = a1[2:0]; sec[0] = a0[2:0];
    gs[3]  = b3[2:0]; gs[2]  = b2[2:0]; gs[1]  = b1[2:0]; gs[0]  = b0[2:0];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      cyc();
      if (done) cnt++;
    end
  endtask

  task automatic score_run(input string name, input bit last, input int e_ex, input int e_pa,
                           input int e_win, input int e_go);
    int lat;
    bit seen;
    last_turn = last;
    pulse_start();
    seen = 0;
    lat = 0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      cyc();
      if (done) begin
        seen = 1;
        lat = c;
      end
    end
    check({name, "_done_latency"}, lat, 21);
    check({name, "_exact"}, exact, e_ex);
    check({name, "_partial"}, partial, e_pa);
    check({name, "_win"}, win, e_win);
    check({name, "_game_over"}, game_over, e_go);
    last_turn = 1'b0;
    cyc();
  endtask

  task automatic expect_ignored(input string name);
    int cnt;
    pulse_start();
    check({name, "_busy"}, busy, 0);
    count_dones(30, cnt);
    check({name, "_dones"}, cnt, 0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    last_turn = 1'b0;
    set_code(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    check("reset_exact", exact, 0);
    check("reset_game_over", game_over, 0);
    reset = 1'b0;
    cyc();

    set_code(1, 2, 3, 4, 1, 2, 3, 4);
    score_run("win", 0, 4, 0, 1, 1);
    set_code(1, 2, 3, 4, 4, 3, 2, 1);
    expect_ignored("after_win");
    check("after_win_exact_held", exact, 4);

    do_reset();
    set_code(1, 2, 3, 4, 4, 3, 2, 1);
    score_run("reversed", 0, 0, 4, 0, 0);
    set_code(1, 1, 2, 2, 1, 2, 1, 0);
    score_run("dups", 0, 1, 2, 0, 0);
    set_code(1, 1, 2, 2, 7, 7, 7, 7);
    score_run("nomatch", 0, 0, 0, 0, 0);

    // Second start at N+5 with a winning guess must be dropped.
    set_code(1, 1, 2, 2, 2, 2, 1, 1);
    pulse_start();
    repeat (4) cyc();
    set_code(1, 1, 2, 2, 1, 1, 2, 2);
    pulse_start();
    count_dones(30, cnt);
    check("restart_dones", cnt, 1);
    check("restart_exact", exact, 0);
    check("restart_partial", partial, 4);
    check("restart_win", win, 0);

    // Reset at N+10 discards the job in flight.
    set_code(3, 3, 1, 1, 3, 1, 3, 1);
    pulse_start();
    repeat (9) cyc();
    do_reset();
    check("midreset_partial", partial, 0);
    check("midreset_busy", busy, 0);
    count_dones(30, cnt);
    check("midreset_dones", cnt, 0);
    set_code(0, 1, 2, 3, 0, 1, 3, 2);
    score_run("fresh", 0, 2, 2, 0, 0);

    set_code(5, 5, 5, 0, 0, 5, 6, 6);
    score_run("last_turn", 1, 1, 1, 0, 1);
    expect_ignored("after_last");

    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit narrow;
      narrow = ($urandom % 2) == 0;
      reset = (($urandom % 400) == 0) || (m_go && (($urandom % 16) == 0));
      start = ($urandom % 3) == 0;
      last_turn = ($urandom % 10) == 0;
      for (int k = 0; k < 4; k++) begin
        sec[k] = narrow ? 3'($urandom % 3) : 3'($urandom % 8);
        gs[k]  = narrow ? 3'($urandom % 3) : 3'($urandom % 8);
      end
      cyc();
    end
    reset = 1'b0;
    start = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
